// File: rtl/complex_alu_pipe.sv
// Pipelined complex add/sub/mul/mac unit with valid/ready handshake.
// Three register ranks: operand capture, sums/partial products, narrowed result.
module complex_alu_pipe #(
  parameter int W    = 8,
  parameter int FRAC = 0,
  parameter bit SAT  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic           acc_clr,
  input  logic [2*W-1:0] x,
  input  logic [2*W-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out,
  output logic           ovf
);

  localparam int AW = 2*W + 2;
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (W-1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_MAC = 2'b11} op_e;

  logic adv;

  logic           s0_valid;
  op_e            s0_op;
  logic           s0_clr;
  logic [2*W-1:0] s0_x, s0_y;

  logic                  s1_valid;
  op_e                   s1_op;
  logic                  s1_clr;
  logic signed [2*W-1:0] s1_a, s1_b, s1_c, s1_d;

  logic signed [AW-1:0] acc_re, acc_im;

  // The whole pipe advances as one: any stall at the output freezes every rank.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1 combinational: sums or partial products
  logic signed [W-1:0]   xr, xi, yr, yi;
  logic signed [W:0]     sum_re, sum_im;
  logic signed [2*W-1:0] d_a, d_b, d_c, d_d;

  assign xr = s0_x[2*W-1:W];
  assign xi = s0_x[W-1:0];
  assign yr = s0_y[2*W-1:W];
  assign yi = s0_y[W-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    d_a    = xr * yr;
    d_b    = xi * yi;
    d_c    = xr * yi;
    d_d    = xi * yr;
    sum_re = xr + yr;
    sum_im = xi + yi;
    if (s0_op == OP_SUB) begin
      sum_re = xr - yr;
      sum_im = xi - yi;
    end
    // add/sub reuse the first two product slots for their W+1-bit sums
    if (s0_op == OP_ADD || s0_op == OP_SUB) begin
      d_a = (2*W)'(sum_re);
      d_b = (2*W)'(sum_im);
    end
  end

  // ---------------- stage 2 combinational: result, accumulate, narrow
  function automatic logic [W:0] narrow(input logic signed [AW-1:0] v);
    if (v > MAXV) return {1'b1, SAT ? MAXV[W-1:0] : v[W-1:0]};
    if (v < MINV) return {1'b1, SAT ? MINV[W-1:0] : v[W-1:0]};
    return {1'b0, v[W-1:0]};
  endfunction

  logic signed [AW-1:0] prod_re, prod_im, acc_base_re, acc_base_im;
  logic signed [AW-1:0] acc_nxt_re, acc_nxt_im, pre_re, pre_im;
  logic [W:0]           nr_re, nr_im;

  always_comb begin
    prod_re     = AW'(s1_a) - AW'(s1_b);
    prod_im     = AW'(s1_c) + AW'(s1_d);
    acc_base_re = s1_clr ? '0 : acc_re;
    acc_base_im = s1_clr ? '0 : acc_im;
    acc_nxt_re  = acc_base_re + prod_re;
    acc_nxt_im  = acc_base_im + prod_im;
    case (s1_op)
      OP_MUL: begin
        pre_re = prod_re >>> FRAC;
        pre_im = prod_im >>> FRAC;
      end
      OP_MAC: begin
        pre_re = acc_nxt_re >>> FRAC;
        pre_im = acc_nxt_im >>> FRAC;
      end
      default: begin
        pre_re = AW'(s1_a);
        pre_im = AW'(s1_b);
      end
    endcase
    nr_re = narrow(pre_re);
    nr_im = narrow(pre_im);
  end

  // ---------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments make every rank sample pre-edge values.
      s0_valid <= in_valid;
      s1_valid <= s0_valid;
    end
  end

  // NOTE: datapath ranks carry no reset; their valid bits already qualify them.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s0_op  <= op_e'(op);
      s0_clr <= acc_clr;
      s0_x   <= x;
      s0_y   <= y;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && s0_valid) begin
      s1_op  <= s0_op;
      s1_clr <= s0_clr;
      s1_a   <= d_a;
      s1_b   <= d_b;
      s1_c   <= d_c;
      s1_d   <= d_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      acc_re    <= '0;
      acc_im    <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out <= {nr_re[W-1:0], nr_im[W-1:0]};
        ovf <= nr_re[W] | nr_im[W];
        if (s1_op == OP_MAC) begin
          acc_re <= acc_nxt_re;
          acc_im <= acc_nxt_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_complex_alu_pipe.sv
// Scoreboard bench: three instances (sat/frac=0, wrap/frac=0, sat/frac=4) share stimulus;
// an integer reference model predicts each result, a negedge monitor compares.
module tb_complex_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic        acc_clr;
  logic [15:0] x, y;
  logic        out_ready = 1'b1;

  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic [15:0] out_v       [3];
  logic        ovf_v       [3];

  always #5 clk = ~clk;

  complex_alu_pipe #(.W(8), .FRAC(0), .SAT(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]), .op(op),
    .acc_clr(acc_clr), .x(x), .y(y), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out(out_v[0]), .ovf(ovf_v[0]));
  complex_alu_pipe #(.W(8), .FRAC(0), .SAT(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]), .op(op),
    .acc_clr(acc_clr), .x(x), .y(y), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out(out_v[1]), .ovf(ovf_v[1]));
  complex_alu_pipe #(.W(8), .FRAC(4), .SAT(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]), .op(op),
    .acc_clr(acc_clr), .x(x), .y(y), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out(out_v[2]), .ovf(ovf_v[2]));

  typedef struct packed {
    logic [2:0][15:0] o;
    logic [2:0]       v;
  } exp_t;

  exp_t   sb[$];
  longint acc_re [3];
  longint acc_im [3];
  int     n_vec = 0;
  int     n_err = 0;
  logic   stall_req = 1'b0;
  logic   rand_bp   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic)
  function automatic longint wrapn(input longint v, input int n);
    longint m = longint'(1) << n;
    longint r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic logic [8:0] narrow(input longint v, input bit sat);
    if (v > 127)  return {1'b1, sat ? 8'd127 : 8'(wrapn(v, 8))};
    if (v < -128) return {1'b1, sat ? 8'h80  : 8'(wrapn(v, 8))};
    return {1'b0, 8'(v)};
  endfunction

  function automatic logic [15:0] pk(input int re, input int im);
    return {8'(re), 8'(im)};
  endfunction

  function automatic void model_push(input logic [1:0] o, input logic c,
                                     input logic [15:0] xa, input logic [15:0] ya);
    longint xr = longint'($signed(xa[15:8]));
    longint xi = longint'($signed(xa[7:0]));
    longint yr = longint'($signed(ya[15:8]));
    longint yi = longint'($signed(ya[7:0]));
    longint pr = xr * yr - xi * yi;
    longint pi = xr * yi + xi * yr;
    exp_t   e;
    for (int k = 0; k < 3; k++) begin
      int         frac = (k == 2) ? 4 : 0;
      bit         sat  = (k != 1);
      longint     rre, rim;
      logic [8:0] nre, nim;
      case (o)
        2'd0: begin rre = xr + yr; rim = xi + yi; end
        2'd1: begin rre = xr - yr; rim = xi - yi; end
        2'd2: begin rre = pr >>> frac; rim = pi >>> frac; end
        default: begin
          acc_re[k] = wrapn((c ? 0 : acc_re[k]) + pr, 18);
          acc_im[k] = wrapn((c ? 0 : acc_im[k]) + pi, 18);
          rre = acc_re[k] >>> frac;
          rim = acc_im[k] >>> frac;
        end
      endcase
      nre     = narrow(rre, sat);
      nim     = narrow(rim, sat);
      e.o[k]  = {nre[7:0], nim[7:0]};
      e.v[k]  = nre[8] | nim[8];
    end
    sb.push_back(e);
  endfunction

  // ---------------- driver helpers
  task automatic send(input logic [1:0] o, input logic c, input logic [15:0] xa, input logic [15:0] ya);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; acc_clr = c; x = xa; y = ya;
    while (!in_ready_v[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    model_push(o, c, xa, ya);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // out_ready changes just after the rising edge so it is stable at the negedge
  always @(posedge clk) begin
    #1;
    if (stall_req)    out_ready = 1'b0;
    else if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    else              out_ready = 1'b1;
  end

  // ---------------- monitor
  logic        held = 1'b0;
  logic [16:0] held_val;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", 64'(out_valid_v[0]), 64'd1);
        check("stall_hold", 64'({ovf_v[0], out_v[0]}), 64'(held_val));
      end
      held     = out_valid_v[0] && !out_ready;
      held_val = {ovf_v[0], out_v[0]};
      if (held) check("stall_in_ready", 64'(in_ready_v[0]), 64'd0);
      if (out_valid_v[0] && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: out=%0h with no pending beat", out_v[0]);
        end else begin
          mon_e = sb.pop_front();
          for (int k = 0; k < 3; k++) begin
            check($sformatf("valid_u%0d", k), 64'(out_valid_v[k]), 64'd1);
            check($sformatf("out_u%0d", k), 64'(out_v[k]), 64'(mon_e.o[k]));
            check($sformatf("ovf_u%0d", k), 64'(ovf_v[k]), 64'(mon_e.v[k]));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 2'd0; acc_clr = 1'b0; x = '0; y = '0;
    for (int k = 0; k < 3; k++) begin acc_re[k] = 0; acc_im[k] = 0; end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_u%0d", k), 64'(out_valid_v[k]), 64'd0);
      check($sformatf("rst_out_u%0d", k), 64'(out_v[k]), 64'd0);
      check($sformatf("rst_ovf_u%0d", k), 64'(ovf_v[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready_v[0]), 64'd1);

    // latency on an empty pipe: result appears after the second edge past accept
    send(2'd0, 1'b0, pk(4, 2), pk(3, 6));
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); check("lat_edge_n1", 64'(out_valid_v[0]), 64'd0);
    @(negedge clk); check("lat_edge_n2", 64'(out_valid_v[0]), 64'd1);

    // directed vectors
    send(2'd1, 1'b0, pk(4, 2),      pk(3, 6));
    send(2'd2, 1'b0, pk(4, 2),      pk(3, 6));
    send(2'd2, 1'b0, pk(-128, 0),   pk(-128, 0));
    send(2'd0, 1'b0, pk(100, -100), pk(100, -100));
    send(2'd3, 1'b1, pk(1, 1),      pk(2, 0));
    send(2'd3, 1'b0, pk(0, 1),      pk(0, 1));
    send(2'd3, 1'b1, pk(1, 0),      pk(1, 0));
    send(2'd0, 1'b1, pk(5, 5),      pk(1, 1));
    send(2'd2, 1'b0, pk(16, 0),     pk(24, 0));
    idle(4);
    drain();

    // backpressure: six adds with out_ready forced low for three cycles
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'd0, 1'b0, 16'($urandom), 16'($urandom));
        idle(1);
      end
      begin
        repeat (3) @(posedge clk);
        stall_req = 1'b1;
        repeat (3) @(posedge clk);
        stall_req = 1'b0;
      end
    join
    drain();

    // randomized traffic with random gaps and backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    rand_bp = 1'b0;
    drain();

    // reset in the middle of a stream
    for (int i = 0; i < 4; i++) send(2'd3, 1'b0, 16'($urandom), 16'($urandom));
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst_valid_u%0d", k), 64'(out_valid_v[k]), 64'd0);
      check($sformatf("midrst_out_u%0d", k), 64'(out_v[k]), 64'd0);
      acc_re[k] = 0;
      acc_im[k] = 0;
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_midrst", 64'(in_ready_v[0]), 64'd1);
    send(2'd3, 1'b0, pk(1, 0), pk(1, 0));
    idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
